// File: rtl/dmem_arbiter.sv
// Shares the single byte-lane data-RAM port between the CPU MEM stage and an
// external word-burst master; builds lane write enables and sequences bursts.
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_misalign,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [3:0]        ext_len,
  input  logic [31:0]       ext_wdata,
  output logic              ext_beat,
  output logic [31:0]       ext_rdata,
  output logic              ext_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] S_CPU = 2'd0;
  localparam logic [1:0] S_EXT = 2'd1;
  localparam logic [1:0] S_GAP = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [7:0]        run;
  logic [7:0]        runNext;
  logic [3:0]        beat;
  logic [3:0]        beatNext;
  logic [3:0]        len;
  logic [ADDR_W-1:0] base;
  logic              dir;
  logic              grant;
  logic              lastBeat;
  logic              cpuMis;
  logic [3:0]        cpuLanes;
  logic [ADDR_W-1:0] beatAddr;

  // Address bits outside the RAM window are intentionally ignored.
  logic unusedBits;
  assign unusedBits = ^{cpu_addr[31:ADDR_W+2], ext_addr[31:ADDR_W+2], ext_addr[1:0]};

  // Lane select, bit n = byte lane n.
  function automatic logic [3:0] laneSel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // The bank enables are numbered in reverse lane order.
  function automatic logic [3:0] laneToWe(input logic [3:0] sel);
    return {sel[0], sel[1], sel[2], sel[3]};
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      2'b00:   data = {4{wdata[7:0]}};
      2'b01:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  assign lastBeat = (beat == len);
  assign beatAddr = base + ADDR_W'(beat);
  assign cpuMis   = cpu_req & isMisaligned(cpu_size, cpu_addr[1:0]);
  assign cpuLanes = laneSel(cpu_size, cpu_addr[1:0]);

  always_comb begin
    stateNext = state;
    runNext   = run;
    beatNext  = beat;
    grant     = 1'b0;
    case (state)
      S_CPU: begin
        if (!ext_req) begin
          runNext = 8'd0;
        end else if (!cpu_req || run == HOLD_LAST) begin
          grant     = 1'b1;
          stateNext = S_EXT;
          runNext   = 8'd0;
          beatNext  = 4'd0;
        end else begin
          runNext = run + 8'd1;
        end
      end
      S_EXT: begin
        if (lastBeat) begin
          stateNext = S_GAP;
        end else begin
          beatNext = beat + 4'd1;
        end
      end
      default: stateNext = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_CPU;
      run   <= 8'd0;
      beat  <= 4'd0;
      base  <= '0;
      len   <= 4'd0;
      dir   <= 1'b0;
    end else begin
      state <= stateNext;
      run   <= runNext;
      beat  <= beatNext;
      if (grant) begin
        base <= ext_addr[ADDR_W+1:2];
        len  <= ext_len;
        dir  <= ext_we;
      end
    end
  end

  // Port steering: burst beats own the RAM in S_EXT, the CPU otherwise.
  always_comb begin
    cpu_rdata    = ram_rdata;
    cpu_stall    = 1'b0;
    cpu_misalign = 1'b0;
    ext_beat     = 1'b0;
    ext_done     = 1'b0;
    ext_rdata    = 32'd0;
    ram_addr     = cpu_addr[ADDR_W+1:2];
    ram_we       = 4'b0000;
    ram_wdata    = laneData(cpu_size, cpu_wdata);
    if (state == S_EXT) begin
      ram_addr  = beatAddr;
      ram_wdata = ext_wdata;
      ram_we    = dir ? 4'b1111 : 4'b0000;
      ext_rdata = dir ? 32'd0 : ram_rdata;
      ext_beat  = 1'b1;
      ext_done  = lastBeat;
      cpu_stall = cpu_req;
    end else begin
      cpu_misalign = cpuMis;
      if (cpu_req && cpu_we && !cpuMis) begin
        ram_we = laneToWe(cpuLanes);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of port ownership and RAM contents.
module tb_dmem_arbiter;

  localparam int AW    = 14;
  localparam int HM    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          clrn;
  logic          cpu_req, cpu_we;
  logic [1:0]    cpu_size;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall, cpu_misalign;
  logic          ext_req, ext_we;
  logic [31:0]   ext_addr, ext_wdata, ext_rdata;
  logic [3:0]    ext_len;
  logic          ext_beat, ext_done;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .HOLD_MAX(HM)) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_misalign(cpu_misalign),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_beat(ext_beat), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Byte-lane banks, written on the falling edge.
  logic [31:0] bank [0:DEPTH-1];
  bit bankInit = 1'b0;
  always @(negedge clk) begin
    if (!bankInit) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= pat(i);
      bankInit <= 1'b1;
    end else begin
      for (int n = 0; n < 4; n++)
        if (ram_we[3-n]) bank[ram_addr][8*n +: 8] <= ram_wdata[8*n +: 8];
    end
  end
  assign ram_rdata = bank[ram_addr];

  // Reference model state
  logic [31:0] refMem [0:DEPTH-1];
  bit          busy, gap, bWrite;
  int          beatNo, beatsLeft, bBase, held;

  int checks = 0;
  int failures = 0;
  logic        sawBeat, sawDone, capStall, capMis;
  logic [3:0]  capWe;
  logic [31:0] capWd, capAddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    busy = 0; gap = 0; bWrite = 0; beatNo = 0; beatsLeft = 0; bBase = 0; held = 0;
  endtask

  task automatic setCpu(input logic req, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wd;
  endtask

  // Check one cycle's outputs against the model, then advance to the next cycle.
  task automatic cycle();
    logic [31:0] eAddr, eWd, eXr;
    logic [3:0]  eWe;
    logic        eBeat, eDone, eStall, eMis;
    int a, off, nb;
    #3;
    eWe = 4'b0000;
    if (busy) begin
      a      = (bBase + beatNo) % DEPTH;
      eWe    = bWrite ? 4'b1111 : 4'b0000;
      eWd    = ext_wdata;
      eBeat  = 1'b1;
      eDone  = (beatsLeft == 0);
      eStall = cpu_req;
      eMis   = 1'b0;
      eXr    = bWrite ? 32'd0 : refMem[a];
    end else begin
      a   = int'((cpu_addr >> 2) % DEPTH);
      off = int'(cpu_addr % 4);
      nb  = (cpu_size == 2'd0) ? 1 : (cpu_size == 2'd1) ? 2 : 4;
      eMis = cpu_req && ((off % nb) != 0);
      eWd  = 32'd0;
      for (int n = 0; n < 4; n++) begin
        eWd[8*n +: 8] = cpu_wdata[8*(n % nb) +: 8];
        if (cpu_req && cpu_we && !eMis && n >= off && n < off + nb) eWe[3-n] = 1'b1;
      end
      eBeat = 1'b0; eDone = 1'b0; eStall = 1'b0; eXr = 32'd0;
    end
    eAddr = 32'(a);
    chk("ram_addr", 32'(ram_addr), eAddr);
    chk("ram_we", 32'(ram_we), 32'(eWe));
    chk("ram_wdata", ram_wdata, eWd);
    chk("cpu_rdata", cpu_rdata, refMem[a]);
    chk("cpu_stall", 32'(cpu_stall), 32'(eStall));
    chk("cpu_misalign", 32'(cpu_misalign), 32'(eMis));
    chk("ext_beat", 32'(ext_beat), 32'(eBeat));
    chk("ext_done", 32'(ext_done), 32'(eDone));
    if (!(busy && bWrite)) chk("ext_rdata", ext_rdata, eXr);
    sawBeat = ext_beat; sawDone = ext_done; capStall = cpu_stall; capMis = cpu_misalign;
    capWe = ram_we; capWd = ram_wdata; capAddr = 32'(ram_addr);
    for (int n = 0; n < 4; n++)
      if (eWe[3-n]) refMem[a][8*n +: 8] = eWd[8*n +: 8];
    if (!clrn) begin
      modelReset();
    end else if (busy) begin
      if (beatsLeft == 0) begin busy = 0; gap = 1; end
      else begin beatsLeft--; beatNo++; end
    end else if (gap) begin
      gap = 0;
    end else if (!ext_req) begin
      held = 0;
    end else if (!cpu_req || held == HM - 1) begin
      busy = 1; beatNo = 0; beatsLeft = int'(ext_len);
      bBase = int'((ext_addr >> 2) % DEPTH); bWrite = ext_we; held = 0;
    end else begin
      held++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cpuCycles;
    logic [31:0] burstAddrs [4];
    burstAddrs[0] = 32'h3FFE; burstAddrs[1] = 32'h3FFF;
    burstAddrs[2] = 32'h0000; burstAddrs[3] = 32'h0001;
    for (int i = 0; i < DEPTH; i++) refMem[i] = pat(i);
    modelReset();
    clrn = 1'b0;
    setCpu(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200; ext_len = 4'd1; ext_wdata = 32'd0;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset held with ext_req pending: CPU owns the port, nothing granted.
    repeat (2) begin
      cycle();
      chk("rst_beat", 32'(sawBeat), 32'd0);
      chk("rst_we", 32'(capWe), 32'd0);
    end
    clrn = 1'b1;
    cycle();
    chk("rel_beat", 32'(sawBeat), 32'd0);
    ext_req = 1'b0;
    cycle();
    chk("grant_beat", 32'(sawBeat), 32'd1);
    cycle();
    chk("grant_done", 32'(sawDone), 32'd1);
    cycle();
    chk("gap_beat", 32'(sawBeat), 32'd0);

    // CPU stores of each size.
    setCpu(1'b1, 1'b1, 2'd0, 32'h102, 32'h000000A5);
    cycle();
    chk("sb_we", 32'(capWe), 32'h2);
    chk("sb_wd", capWd, 32'hA5A5A5A5);
    chk("sb_addr", capAddr, 32'h40);
    setCpu(1'b1, 1'b1, 2'd1, 32'h106, 32'h0000BEEF);
    cycle();
    chk("sh_we", 32'(capWe), 32'h3);
    chk("sh_wd", capWd, 32'hBEEFBEEF);
    chk("sh_addr", capAddr, 32'h41);
    setCpu(1'b1, 1'b1, 2'd2, 32'h10, 32'h11223344);
    cycle();
    chk("sw_we", 32'(capWe), 32'hF);
    chk("sw_wd", capWd, 32'h11223344);
    chk("sw_addr", capAddr, 32'h4);

    // Misaligned accesses are suppressed.
    setCpu(1'b1, 1'b1, 2'd1, 32'h101, 32'h0000DEAD);
    cycle();
    chk("mis_h", 32'(capMis), 32'd1);
    chk("mis_h_we", 32'(capWe), 32'd0);
    setCpu(1'b1, 1'b1, 2'd2, 32'h102, 32'hCAFEF00D);
    cycle();
    chk("mis_w", 32'(capMis), 32'd1);
    chk("mis_w_we", 32'(capWe), 32'd0);
    setCpu(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
    cycle();
    setCpu(1'b1, 1'b0, 2'd3, 32'h104, 32'd0);
    cycle();

    // External write burst wrapping past the top of the RAM.
    setCpu(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000FFF8; ext_len = 4'd3;
    cycle();
    ext_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ext_wdata = $urandom;
      cycle();
      chk("wb_addr", capAddr, burstAddrs[i]);
      chk("wb_beat", 32'(sawBeat), 32'd1);
      chk("wb_done", 32'(sawDone), (i == 3) ? 32'd1 : 32'd0);
    end
    cycle();
    chk("wb_gap", 32'(sawBeat), 32'd0);
    for (int i = 0; i < 2; i++) begin
      setCpu(1'b1, 1'b0, 2'd2, 32'h0000FFF8 + 32'(4 * i), 32'd0);
      cycle();
    end

    // Continuous CPU traffic holds off a pending burst for HOLD_MAX cycles.
    setCpu(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    cycle();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0000FFF8; ext_len = 4'd1;
    cpuCycles = 0;
    for (int i = 0; i < 20; i++) begin
      setCpu(1'b1, 1'b1, 2'($urandom_range(0, 2)), 32'($urandom_range(0, 255)) & 32'hFFFFFFFC, $urandom);
      cycle();
      if (sawBeat) break;
      cpuCycles++;
    end
    chk("hold_cycles", 32'(cpuCycles), 32'(HM));
    chk("hold_stall0", 32'(capStall), 32'd1);
    cycle();
    chk("hold_stall1", 32'(capStall), 32'd1);
    chk("hold_done", 32'(sawDone), 32'd1);
    cycle();
    chk("hold_gap_stall", 32'(capStall), 32'd0);
    chk("hold_gap_beat", 32'(sawBeat), 32'd0);
    ext_req = 1'b0;
    cycle();

    // Reset in the middle of a long burst aborts it.
    setCpu(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h400; ext_len = 4'd7;
    cycle();
    ext_req = 1'b0;
    repeat (2) begin
      cycle();
      chk("abort_pre_done", 32'(sawDone), 32'd0);
    end
    clrn = 1'b0;
    modelReset();
    cycle();
    chk("abort_beat", 32'(sawBeat), 32'd0);
    chk("abort_done", 32'(sawDone), 32'd0);
    clrn = 1'b1;
    setCpu(1'b1, 1'b1, 2'd2, 32'h20, $urandom);
    cycle();
    chk("abort_cpu_we", 32'(capWe), 32'hF);
    chk("abort_cpu_stall", 32'(capStall), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        setCpu(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        clrn = 1'b0;
        modelReset();
        cycle();
        clrn = 1'b1;
      end
      setCpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 511)) : $urandom, $urandom);
      ext_req   = ($urandom_range(0, 3) == 0);
      ext_we    = 1'($urandom_range(0, 1));
      ext_addr  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 511)) : $urandom;
      ext_len   = 4'($urandom_range(0, 15));
      ext_wdata = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
